// File: rtl/sal_sched_pkg.sv
// Command encoding shared by the channel scheduler and the PHY command encoder.
package sal_sched_pkg;
  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } cmd_e;
endpackage

// File: rtl/sal_rr_arbiter.sv
// Round-robin pick of the first requester at or after ptr; purely combinational.
// Several instances share one pointer so fairness is tracked per channel, not per class.
module sal_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  always_comb begin
    logic [IW-1:0] idx;
    idx     = '0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + IW'(i);  // wraps naturally, N is a power of two
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sal_cmd_sched.sv
// Channel command scheduler: same-cycle grant to one bank, command bus registered one cycle later.
// No backpressure from the PHY; ineligible or losing requests are simply not granted this cycle.
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int BA_WIDTH   = 2,
  parameter int RA_WIDTH   = 14,
  parameter int CA_WIDTH   = 10,
  parameter int TCNT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANKS-1:0]          act_req_i,
  input  logic [NUM_BANKS-1:0]          rd_req_i,
  input  logic [NUM_BANKS-1:0]          wr_req_i,
  input  logic [NUM_BANKS-1:0]          pre_req_i,
  input  logic [NUM_BANKS-1:0]          ref_req_i,
  input  logic [NUM_BANKS*RA_WIDTH-1:0] ra_i,
  input  logic [NUM_BANKS*CA_WIDTH-1:0] ca_i,
  output logic [NUM_BANKS-1:0]          act_gnt_o,
  output logic [NUM_BANKS-1:0]          rd_gnt_o,
  output logic [NUM_BANKS-1:0]          wr_gnt_o,
  output logic [NUM_BANKS-1:0]          pre_gnt_o,
  output logic [NUM_BANKS-1:0]          ref_gnt_o,
  input  logic [TCNT_WIDTH-1:0]         t_rrd_i,
  input  logic [TCNT_WIDTH-1:0]         t_ccd_i,
  input  logic [TCNT_WIDTH-1:0]         t_wtr_i,
  input  logic [TCNT_WIDTH-1:0]         t_rtw_i,
  output logic                          cmd_valid_o,
  output cmd_e                          cmd_o,
  output logic [BA_WIDTH-1:0]           cmd_ba_o,
  output logic [RA_WIDTH-1:0]           cmd_addr_o
);
  logic [TCNT_WIDTH-1:0] rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
  logic [BA_WIDTH-1:0]   ptr;

  logic [NUM_BANKS-1:0] rd_el, wr_el, col_el, act_el;
  logic [NUM_BANKS-1:0] ref_g, col_g, act_g, pre_g;
  logic [BA_WIDTH-1:0]  ref_idx, col_idx, act_idx, pre_idx;
  logic                 ref_any, col_any, act_any, pre_any;

  assign rd_el  = rd_req_i  & {NUM_BANKS{(ccd_cnt == '0) && (wtr_cnt == '0)}};
  assign wr_el  = wr_req_i  & {NUM_BANKS{(ccd_cnt == '0) && (rtw_cnt == '0)}};
  assign col_el = rd_el | wr_el;
  assign act_el = act_req_i & {NUM_BANKS{rrd_cnt == '0}};

  sal_rr_arbiter #(.N(NUM_BANKS), .IW(BA_WIDTH)) u_arb_ref (
    .req(ref_req_i), .ptr(ptr), .gnt(ref_g), .gnt_idx(ref_idx), .any(ref_any));
  sal_rr_arbiter #(.N(NUM_BANKS), .IW(BA_WIDTH)) u_arb_col (
    .req(col_el), .ptr(ptr), .gnt(col_g), .gnt_idx(col_idx), .any(col_any));
  sal_rr_arbiter #(.N(NUM_BANKS), .IW(BA_WIDTH)) u_arb_act (
    .req(act_el), .ptr(ptr), .gnt(act_g), .gnt_idx(act_idx), .any(act_any));
  sal_rr_arbiter #(.N(NUM_BANKS), .IW(BA_WIDTH)) u_arb_pre (
    .req(pre_req_i), .ptr(ptr), .gnt(pre_g), .gnt_idx(pre_idx), .any(pre_any));

  cmd_e                sel_cmd;
  logic [BA_WIDTH-1:0] sel_ba;
  logic [RA_WIDTH-1:0] sel_addr;

  always_comb begin
    sel_cmd  = NOP;
    sel_ba   = '0;
    sel_addr = '0;
    // nothing is eligible while reset is held, even though counters read as met
    if (!rst) begin
      if (ref_any) begin
        sel_cmd = REF;
        sel_ba  = ref_idx;
      end else if (col_any) begin
        sel_cmd = rd_el[col_idx] ? RD : WR;
        sel_ba  = col_idx;
      end else if (act_any) begin
        sel_cmd = ACT;
        sel_ba  = act_idx;
      end else if (pre_any) begin
        sel_cmd = PRE;
        sel_ba  = pre_idx;
      end
    end
    if (sel_cmd == ACT)
      sel_addr = ra_i[int'(sel_ba)*RA_WIDTH +: RA_WIDTH];
    else if (sel_cmd == RD || sel_cmd == WR)
      sel_addr = RA_WIDTH'(ca_i[int'(sel_ba)*CA_WIDTH +: CA_WIDTH]);
  end

  logic [NUM_BANKS-1:0] sel_oh;
  assign sel_oh    = NUM_BANKS'(1) << sel_ba;
  assign act_gnt_o = (sel_cmd == ACT) ? sel_oh : '0;
  assign rd_gnt_o  = (sel_cmd == RD)  ? sel_oh : '0;
  assign wr_gnt_o  = (sel_cmd == WR)  ? sel_oh : '0;
  assign pre_gnt_o = (sel_cmd == PRE) ? sel_oh : '0;
  assign ref_gnt_o = (sel_cmd == REF) ? sel_oh : '0;

  // load t-1 so the next constrained command lands exactly t cycles after this grant
  function automatic logic [TCNT_WIDTH-1:0] next_cnt(input logic load,
                                                     input logic [TCNT_WIDTH-1:0] cnt,
                                                     input logic [TCNT_WIDTH-1:0] t);
    if (load) return (t == '0) ? '0 : t - 1'b1;
    return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrd_cnt     <= '0;
      ccd_cnt     <= '0;
      wtr_cnt     <= '0;
      rtw_cnt     <= '0;
      ptr         <= '0;
      cmd_valid_o <= 1'b0;
      cmd_o       <= NOP;
      cmd_ba_o    <= '0;
      cmd_addr_o  <= '0;
    end else begin
      rrd_cnt     <= next_cnt(sel_cmd == ACT, rrd_cnt, t_rrd_i);
      ccd_cnt     <= next_cnt(sel_cmd == RD || sel_cmd == WR, ccd_cnt, t_ccd_i);
      wtr_cnt     <= next_cnt(sel_cmd == WR, wtr_cnt, t_wtr_i);
      rtw_cnt     <= next_cnt(sel_cmd == RD, rtw_cnt, t_rtw_i);
      if (sel_cmd != NOP) ptr <= sel_ba + 1'b1;
      cmd_valid_o <= (sel_cmd != NOP);
      cmd_o       <= sel_cmd;
      cmd_ba_o    <= sel_ba;
      cmd_addr_o  <= sel_addr;
    end
  end
endmodule

// File: tb/tb_sal_cmd_sched.sv
// Bench for sal_cmd_sched: reset, vector table, directed timing sequences, random vs. reference model.
module tb_sal_cmd_sched;
  import sal_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  act_req, rd_req, wr_req, pre_req, ref_req;
  logic [55:0] ra;
  logic [39:0] ca;
  logic [3:0]  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [3:0]  t_rrd, t_ccd, t_wtr, t_rtw;
  logic        cmd_valid;
  cmd_e        cmd;
  logic [1:0]  cmd_ba;
  logic [13:0] cmd_addr;

  always #5 clk = ~clk;

  sal_cmd_sched dut (
    .clk(clk), .rst(rst),
    .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
    .pre_req_i(pre_req), .ref_req_i(ref_req),
    .ra_i(ra), .ca_i(ca),
    .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
    .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
    .t_rrd_i(t_rrd), .t_ccd_i(t_ccd), .t_wtr_i(t_wtr), .t_rtw_i(t_rtw),
    .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_ba_o(cmd_ba), .cmd_addr_o(cmd_addr)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] a, r, w, p, f);
    return {a, r, w, p, f};
  endfunction

  function automatic logic [19:0] gv();
    return {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};
  endfunction

  function automatic logic [13:0] exp_addr(input cmd_e c, input logic [1:0] b);
    if (c == ACT) return ra[int'(b)*14 +: 14];
    if (c == RD || c == WR) return {4'b0, ca[int'(b)*10 +: 10]};
    return 14'h0;
  endfunction

  task automatic drive(input logic [3:0] a, r, w, p, f);
    act_req = a; rd_req = r; wr_req = w; pre_req = p; ref_req = f;
  endtask

  // Called at posedge+1 with inputs driven; leaves at the following posedge+1.
  task automatic step(input string name, input logic [19:0] eg, input cmd_e ec, input logic [1:0] eb);
    logic [13:0] ea;
    #4;
    chk({name, "_gnt"}, 32'(gv()), 32'(eg));
    ea = exp_addr(ec, eb);
    @(posedge clk); #1;
    chk({name, "_cmd"}, 32'({cmd_valid, cmd, cmd_ba, cmd_addr}),
        32'({ec != NOP, ec, (ec == NOP) ? 2'd0 : eb, ea}));
  endtask

  // Reference model: remembers when each command kind was last granted.
  int mptr, mcyc, last_act, last_col, last_rd, last_wr;

  function automatic int m1(input logic [3:0] t);
    return (t == 0) ? 1 : int'(t);
  endfunction

  task automatic model_reset();
    mptr = 0; mcyc = 0;
    last_act = -1000; last_col = -1000; last_rd = -1000; last_wr = -1000;
  endtask

  task automatic model_eval(output logic [19:0] eg, output cmd_e ec, output logic [1:0] eb);
    bit rrd_ok, ccd_ok, wtr_ok, rtw_ok, found;
    logic [3:0] oh;
    int b;
    rrd_ok = (mcyc - last_act) >= m1(t_rrd);
    ccd_ok = (mcyc - last_col) >= m1(t_ccd);
    wtr_ok = (mcyc - last_wr)  >= m1(t_wtr);
    rtw_ok = (mcyc - last_rd)  >= m1(t_rtw);
    ec = NOP; eb = 2'd0; found = 0;
    for (int cls = 0; cls < 4; cls++)
      for (int i = 0; i < 4; i++) begin
        b = (mptr + i) % 4;
        if (!found) begin
          case (cls)
            0: if (ref_req[b]) begin ec = REF; found = 1; end
            1: if (rd_req[b] && ccd_ok && wtr_ok) begin ec = RD; found = 1; end
               else if (wr_req[b] && ccd_ok && rtw_ok) begin ec = WR; found = 1; end
            2: if (act_req[b] && rrd_ok) begin ec = ACT; found = 1; end
            default: if (pre_req[b]) begin ec = PRE; found = 1; end
          endcase
          if (found) eb = 2'(b);
        end
      end
    oh = 4'b0001 << eb;
    case (ec)
      ACT:     eg = mk(oh, 0, 0, 0, 0);
      RD:      eg = mk(0, oh, 0, 0, 0);
      WR:      eg = mk(0, 0, oh, 0, 0);
      PRE:     eg = mk(0, 0, 0, oh, 0);
      REF:     eg = mk(0, 0, 0, 0, oh);
      default: eg = 20'h0;
    endcase
  endtask

  task automatic model_commit(input cmd_e ec, input logic [1:0] eb);
    if (ec != NOP) begin
      mptr = (int'(eb) + 1) % 4;
      if (ec == ACT) last_act = mcyc;
      if (ec == RD) begin last_col = mcyc; last_rd = mcyc; end
      if (ec == WR) begin last_col = mcyc; last_wr = mcyc; end
    end
    mcyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  a, r, w, p, f;
    logic [19:0] eg;
    cmd_e        ec;
    logic [1:0]  eb;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [19:0] eg;
    cmd_e        ec;
    logic [1:0]  eb;
    logic [3:0]  oh;
    int          k;

    tbl[0] = '{4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, mk(0, 4'b0001, 0, 0, 0), RD,  2'd0};
    tbl[1] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, mk(4'b0010, 0, 0, 0, 0), ACT, 2'd1};
    tbl[2] = '{4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0100, mk(0, 0, 0, 0, 4'b0100), REF, 2'd2};
    tbl[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000, mk(0, 0, 0, 4'b0001, 0), PRE, 2'd0};
    tbl[4] = '{4'b0000, 4'b0100, 4'b1010, 4'b0000, 4'b0000, mk(0, 0, 4'b0010, 0, 0), WR,  2'd1};
    tbl[5] = '{4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, mk(0, 4'b0100, 0, 0, 0), RD,  2'd2};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 20'h0,                   NOP, 2'd0};
    tbl[7] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, mk(4'b1000, 0, 0, 0, 0), ACT, 2'd3};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, mk(0, 0, 0, 4'b0001, 0), PRE, 2'd0};
    tbl[9] = '{4'b0001, 4'b0000, 4'b0000, 4'b0110, 4'b1000, mk(0, 0, 0, 0, 4'b1000), REF, 2'd3};

    ra = {14'h1ABC, 14'h0222, 14'h0111, 14'h0055};
    ca = {10'h3C3, 10'h2B2, 10'h1A1, 10'h090};
    t_rrd = 0; t_ccd = 0; t_wtr = 0; t_rtw = 0;

    // Reset state: requests present but nothing granted, command bus idle
    rst = 1'b1;
    drive(4'hF, 4'hF, 0, 4'hF, 0);
    #12;
    chk("reset_gnt", 32'(gv()), 32'h0);
    chk("reset_cmd", 32'({cmd_valid, cmd, cmd_ba, cmd_addr}), 32'h0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a, tbl[i].r, tbl[i].w, tbl[i].p, tbl[i].f);
      step($sformatf("tbl%0d", i), tbl[i].eg, tbl[i].ec, tbl[i].eb);
    end

    // Async reset mid-cycle after an RD grant clears bus, counters and pointer
    do_reset();
    t_ccd = 4'd8;
    drive(0, 4'b0001, 0, 0, 0);
    step("mr_rd", mk(0, 4'b0001, 0, 0, 0), RD, 2'd0);
    drive(0, 4'b0011, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("mr_async_cmd", 32'({cmd_valid, cmd, cmd_ba, cmd_addr}), 32'h0);
    chk("mr_async_gnt", 32'(gv()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step("mr_after", mk(0, 4'b0001, 0, 0, 0), RD, 2'd0);

    // tRRD=4 with all banks requesting ACT
    do_reset();
    t_ccd = 0; t_rrd = 4'd4;
    drive(4'b1111, 0, 0, 0, 0);
    for (int c = 0; c < 13; c++) begin
      oh = 4'b0001 << (c / 4);
      if (c % 4 == 0) step($sformatf("rrd_c%0d", c), mk(oh, 0, 0, 0, 0), ACT, 2'(c / 4));
      else            step($sformatf("rrd_c%0d", c), 20'h0, NOP, 2'd0);
    end

    // WR then RD: tWTR=6 dominates tCCD=2
    do_reset();
    t_rrd = 0; t_wtr = 4'd6; t_ccd = 4'd2;
    drive(0, 0, 4'b0001, 0, 0);
    step("wtr_c0", mk(0, 0, 4'b0001, 0, 0), WR, 2'd0);
    drive(0, 4'b0010, 0, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) step("wtr_c6", mk(0, 4'b0010, 0, 0, 0), RD, 2'd1);
      else        step($sformatf("wtr_c%0d", c), 20'h0, NOP, 2'd0);
    end

    // tRRD=0: ACT to bank 3 back-to-back with its row address on the bus
    do_reset();
    t_wtr = 0; t_ccd = 0; t_rrd = 0;
    drive(4'b1000, 0, 0, 0, 0);
    step("b2b_act0", mk(4'b1000, 0, 0, 0, 0), ACT, 2'd3);
    step("b2b_act1", mk(4'b1000, 0, 0, 0, 0), ACT, 2'd3);

    // Randomized traffic against the reference model
    for (int blk = 0; blk < 3; blk++) begin
      t_rrd = 4'($urandom_range(0, 5));
      t_ccd = 4'($urandom_range(0, 5));
      t_wtr = 4'($urandom_range(0, 7));
      t_rtw = 4'($urandom_range(0, 5));
      do_reset();
      for (int n = 0; n < 200; n++) begin
        drive(0, 0, 0, 0, 0);
        for (int b = 0; b < 4; b++) begin
          k = int'($urandom_range(0, 12));
          case (k)
            0, 1:    act_req[b] = 1'b1;
            2, 3:    rd_req[b]  = 1'b1;
            4, 5:    wr_req[b]  = 1'b1;
            6:       pre_req[b] = 1'b1;
            7:       if ($urandom_range(0, 3) == 0) ref_req[b] = 1'b1;
            default: ;
          endcase
        end
        ra = {$urandom, $urandom};
        ca = {8'($urandom), $urandom};
        model_eval(eg, ec, eb);
        step($sformatf("rnd%0d_%0d", blk, n), eg, ec, eb);
        model_commit(ec, eb);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
